// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential fully-connected layer.
// A captured input vector is multiplied against a weight matrix one product
// per clock.
// Each neuron output is bias + dot(weights, inputs), shifted right by
// FRAC_BITS and saturated to the activation range.
// Weights and biases live in local storage. They are loaded through simple
// write strobes while the block is idle, and reset does not clear them.
// Optional feature macro: FC_LAYER_RELU_EN clamps negative outputs to zero.
//
// Handshake (valid/ready): a transfer happens on a rising edge where both
// valid and ready are 1.
//   input side : in_valid/in_ready. in_ready is 1 only in IDLE.
//   output side: out_valid/out_ready. data_out is held stable while
//                out_valid=1 and out_ready=0.
//
// The datapath is a two-stage pipeline: the weight*activation product is
// registered, then added into the accumulator on the following edge. This
// makes out_valid rise OUTPUT_SIZE*INPUT_SIZE+1 edges after the accept edge.
module fc_layer_seq #(
  parameter int INPUT_SIZE  = 160,
  parameter int OUTPUT_SIZE = 64,
  parameter int ACTIV_BITS  = 8,
  parameter int WEIGHT_BITS = 8,
  parameter int ACC_BITS    = 32,
  parameter int FRAC_BITS   = 0,
  localparam int NW          = OUTPUT_SIZE * INPUT_SIZE,
  localparam int W_ADDR_BITS = (NW > 1) ? $clog2(NW) : 1,
  localparam int B_ADDR_BITS = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [INPUT_SIZE*ACTIV_BITS-1:0]    data_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [OUTPUT_SIZE*ACTIV_BITS-1:0]   data_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  input  logic                                w_wr_en,
  input  logic [W_ADDR_BITS-1:0]              w_addr,
  input  logic [WEIGHT_BITS-1:0]              w_data,
  input  logic                                b_wr_en,
  input  logic [B_ADDR_BITS-1:0]              b_addr,
  input  logic [WEIGHT_BITS-1:0]              b_data
);

  localparam int I_BITS    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int PROD_BITS = WEIGHT_BITS + ACTIV_BITS;

  localparam logic [W_ADDR_BITS-1:0] W_LAST  = W_ADDR_BITS'(NW - 1);
  localparam logic [I_BITS-1:0]      I_LAST  = I_BITS'(INPUT_SIZE - 1);
  localparam logic [B_ADDR_BITS-1:0] O_LAST  = B_ADDR_BITS'(OUTPUT_SIZE - 1);
  localparam logic [W_ADDR_BITS:0]   W_LIMIT = (W_ADDR_BITS + 1)'(NW);
  localparam logic [B_ADDR_BITS:0]   B_LIMIT = (B_ADDR_BITS + 1)'(OUTPUT_SIZE);

  localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((2 ** (ACTIV_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = ACC_BITS'(-(2 ** (ACTIV_BITS - 1)));
  localparam logic [ACTIV_BITS-1:0]      ACT_MAX = {1'b0, {(ACTIV_BITS - 1){1'b1}}};
  localparam logic [ACTIV_BITS-1:0]      ACT_MIN = {1'b1, {(ACTIV_BITS - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state;

  // Parameter storage, deliberately outside the reset domain.
  logic [WEIGHT_BITS-1:0] w_mem [NW];
  logic [WEIGHT_BITS-1:0] b_mem [OUTPUT_SIZE];

  logic [INPUT_SIZE*ACTIV_BITS-1:0] data_q;

  // Issue stage: walks the weight matrix row by row.
  logic                   issue_on;
  logic [W_ADDR_BITS-1:0] w_idx;
  logic [I_BITS-1:0]      i_idx;
  logic [B_ADDR_BITS-1:0] o_idx;

  // Accumulate stage: the registered product plus tags for its position.
  logic                        p_valid;
  logic                        p_first;
  logic                        p_last;
  logic [B_ADDR_BITS-1:0]      p_o;
  logic signed [PROD_BITS-1:0] prod;
  logic signed [ACC_BITS-1:0]  acc;

  logic signed [PROD_BITS-1:0] prod_next;
  logic signed [ACC_BITS-1:0]  prod_ext;
  logic [WEIGHT_BITS-1:0]      bias_cur;
  logic signed [ACC_BITS-1:0]  bias_init;
  logic signed [ACC_BITS-1:0]  sum;
  logic signed [ACC_BITS-1:0]  shifted;
  logic [ACTIV_BITS-1:0]       sat_val;
  logic [ACTIV_BITS-1:0]       result;
  logic                        i_last;

  // Datapath: product, accumulator update, output shift/saturate/ReLU.
  always_comb begin
    prod_next = $signed(w_mem[w_idx]) * $signed(data_q[i_idx*ACTIV_BITS +: ACTIV_BITS]);
    prod_ext  = {{(ACC_BITS - PROD_BITS){prod[PROD_BITS-1]}}, prod};
    bias_cur  = b_mem[p_o];
    bias_init = $signed({{(ACC_BITS - WEIGHT_BITS){bias_cur[WEIGHT_BITS-1]}}, bias_cur}) <<< FRAC_BITS;
    sum       = (p_first ? bias_init : acc) + prod_ext;
    shifted   = sum >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      sat_val = ACT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat_val = ACT_MIN;
    end else begin
      sat_val = shifted[ACTIV_BITS-1:0];
    end
`ifdef FC_LAYER_RELU_EN
    result = sat_val[ACTIV_BITS-1] ? '0 : sat_val;
`else
    result = sat_val;
`endif
    i_last = (i_idx == I_LAST);
  end

  // Weight/bias loading, accepted only while idle and for in-range addresses.
  always_ff @(posedge clk) begin
    if (state == IDLE && w_wr_en && ({1'b0, w_addr} < W_LIMIT)) begin
      w_mem[w_addr] <= w_data;
    end
    if (state == IDLE && b_wr_en && ({1'b0, b_addr} < B_LIMIT)) begin
      b_mem[b_addr] <= b_data;
    end
  end

  // Control FSM with issue and accumulate pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      acc       <= '0;
      issue_on  <= 1'b0;
      w_idx     <= '0;
      i_idx     <= '0;
      o_idx     <= '0;
      p_valid   <= 1'b0;
      p_first   <= 1'b0;
      p_last    <= 1'b0;
      p_o       <= '0;
      prod      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= data_in;
            w_idx    <= '0;
            i_idx    <= '0;
            o_idx    <= '0;
            issue_on <= 1'b1;
            p_valid  <= 1'b0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          if (issue_on) begin
            prod    <= prod_next;
            p_valid <= 1'b1;
            p_first <= (i_idx == '0);
            p_last  <= i_last;
            p_o     <= o_idx;
            w_idx   <= w_idx + 1'b1;
            if (i_last) begin
              i_idx <= '0;
              o_idx <= o_idx + 1'b1;
            end else begin
              i_idx <= i_idx + 1'b1;
            end
            if (w_idx == W_LAST) begin
              issue_on <= 1'b0;
            end
          end else begin
            p_valid <= 1'b0;
          end
          if (p_valid) begin
            acc <= sum;
            if (p_last) begin
              data_out[p_o*ACTIV_BITS +: ACTIV_BITS] <= result;
              if (p_o == O_LAST) begin
                state     <= OUT;
                out_valid <= 1'b1;
              end
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq with INPUT_SIZE=4 and OUTPUT_SIZE=2.
// Expected vectors come from a reference model of the layer and are queued
// when a vector is sent, then popped when out_valid is seen.
module tb_fc_layer_seq;

  localparam int I  = 4;
  localparam int O  = 2;
  localparam int AB = 8;
  localparam int NW = O * I;

  logic            clk;
  logic            rst;
  logic [I*AB-1:0] data_in;
  logic            in_valid;
  logic            in_ready;
  logic [O*AB-1:0] data_out;
  logic            out_valid;
  logic            out_ready;
  logic            w_wr_en;
  logic [2:0]      w_addr;
  logic [7:0]      w_data;
  logic            b_wr_en;
  logic [0:0]      b_addr;
  logic [7:0]      b_data;

  int errors = 0;
  int checks = 0;

  logic [O*AB-1:0] exp_q[$];
  int              w_model[NW];
  int              b_model[O];

  localparam logic [I*AB-1:0] VEC_1234 = {8'd4, 8'd3, 8'd2, 8'd1};

  fc_layer_seq #(
    .INPUT_SIZE(I), .OUTPUT_SIZE(O), .ACTIV_BITS(8), .WEIGHT_BITS(8),
    .ACC_BITS(32), .FRAC_BITS(0)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .b_wr_en(b_wr_en), .b_addr(b_addr), .b_data(b_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model of one output vector.
  function automatic logic [O*AB-1:0] model_out(input logic [I*AB-1:0] x);
    logic [O*AB-1:0] r;
    int acc;
    int xi;
    r = '0;
    for (int o = 0; o < O; o++) begin
      acc = b_model[o];
      for (int i = 0; i < I; i++) begin
        xi  = int'($signed(x[i*AB +: AB]));
        acc = acc + w_model[o*I + i] * xi;
      end
      if (acc > 127) acc = 127;
      else if (acc < -128) acc = -128;
`ifdef FC_LAYER_RELU_EN
      if (acc < 0) acc = 0;
`endif
      r[o*AB +: AB] = 8'(acc);
    end
    return r;
  endfunction

  // driver tasks
  task automatic write_model;
    for (int k = 0; k < NW; k++) begin
      w_wr_en = 1'b1;
      w_addr  = 3'(k);
      w_data  = 8'(w_model[k]);
      if (k < O) begin
        b_wr_en = 1'b1;
        b_addr  = 1'(k);
        b_data  = 8'(b_model[k]);
      end else begin
        b_wr_en = 1'b0;
      end
      tick();
    end
    w_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  task automatic set_model(input int w, input int b0, input int b1);
    for (int k = 0; k < NW; k++) w_model[k] = w;
    b_model[0] = b0;
    b_model[1] = b1;
  endtask

  // Presents x, waits for acceptance and optionally queues the expected result.
  task automatic start_vector(input logic [I*AB-1:0] x, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL start_wait: in_ready=%0b required 1 within 100 cycles", in_ready);
    end
    data_in  = x;
    in_valid = 1'b1;
    if (push) exp_q.push_back(model_out(x));
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_ready_mac: got %0b required 0", in_ready);
    end
  endtask

  task automatic wait_output(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_timeout: out_valid=%0b required 1 within 200 cycles", out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h required 0000", data_out); end
  endtask

  task automatic test_basic;
    int lat;
    logic [O*AB-1:0] exp;
    set_model(1, 0, 5);
    write_model();
    out_ready = 1'b1;
    start_vector(VEC_1234, 1'b1);
    wait_output(lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL basic_latency: got %0d required 9", lat); end
    checks++;
    if (data_out !== {8'd15, 8'd10}) begin errors++; $display("FAIL basic_value: got %h required 0f0a", data_out); end
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL basic_scoreboard: got %h required %h", data_out, exp); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: out_valid=%0b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: in_ready=%0b required 1", in_ready); end
  endtask

  task automatic test_saturation;
    int lat;
    logic [O*AB-1:0] exp;
    logic [O*AB-1:0] neg_exp;
    out_ready = 1'b1;
    // positive saturation
    set_model(100, 0, 0);
    write_model();
    start_vector({4{8'd100}}, 1'b1);
    wait_output(lat);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== 16'h7F7F) begin errors++; $display("FAIL sat_pos: got %h required 7f7f", data_out); end
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL sat_pos_scoreboard: got %h required %h", data_out, exp); end
    tick();
    // small negative result
`ifdef FC_LAYER_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hF6F6;
`endif
    set_model(-1, 0, 0);
    write_model();
    start_vector(VEC_1234, 1'b1);
    wait_output(lat);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== neg_exp) begin errors++; $display("FAIL neg_small: got %h required %h", data_out, neg_exp); end
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL neg_small_scoreboard: got %h required %h", data_out, exp); end
    tick();
    // negative saturation
`ifdef FC_LAYER_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8080;
`endif
    set_model(-128, 0, 0);
    write_model();
    start_vector({4{8'd127}}, 1'b1);
    wait_output(lat);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== neg_exp) begin errors++; $display("FAIL sat_neg: got %h required %h", data_out, neg_exp); end
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL sat_neg_scoreboard: got %h required %h", data_out, exp); end
    tick();
  endtask

  task automatic test_backpressure;
    int lat;
    logic [O*AB-1:0] exp;
    set_model(1, 0, 5);
    write_model();
    out_ready = 1'b0;
    start_vector(VEC_1234, 1'b1);
    wait_output(lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      data_in  = $urandom_range(0, 32'hFFFF_FFFF);
      w_wr_en  = 1'b1;
      w_addr   = 3'(c);
      w_data   = 8'd50;
      b_wr_en  = 1'b1;
      b_addr   = 1'(c);
      b_data   = 8'd50;
      tick();
      checks++;
      if (data_out !== {8'd15, 8'd10}) begin errors++; $display("FAIL hold_data: cycle %0d got %h required 0f0a", c, data_out); end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_flags: cycle %0d in_ready=%0b out_valid=%0b required 0/1", c, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    w_wr_en  = 1'b0;
    b_wr_en  = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL hold_scoreboard: got %h required %h", data_out, exp); end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: out_valid=%0b required 0", out_valid); end
    // weights must be untouched by the writes issued during OUT
    start_vector(VEC_1234, 1'b1);
    wait_output(lat);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== {8'd15, 8'd10}) begin errors++; $display("FAIL hold_weights_kept: got %h required 0f0a", data_out); end
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL hold_weights_scoreboard: got %h required %h", data_out, exp); end
    tick();
  endtask

  task automatic test_abort;
    int lat;
    bit seen;
    logic [O*AB-1:0] exp;
    out_ready = 1'b1;
    start_vector(VEC_1234, 1'b0);
    // writes during MAC must be ignored
    w_wr_en = 1'b1;
    w_addr  = 3'd0;
    w_data  = 8'd77;
    b_wr_en = 1'b1;
    b_addr  = 1'd0;
    b_data  = 8'd77;
    tick();
    w_wr_en = 1'b0;
    b_wr_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %0b required 1", in_ready); end
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL abort_data_out: got %h required 0000", data_out); end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_output: out_valid rose=%0b required 0", seen); end
    start_vector(VEC_1234, 1'b1);
    wait_output(lat);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== {8'd15, 8'd10}) begin errors++; $display("FAIL abort_resend: got %h required 0f0a", data_out); end
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL abort_resend_scoreboard: got %h required %h", data_out, exp); end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat;
    int d;
    logic [O*AB-1:0] exp;
    logic [I*AB-1:0] x;
    for (int k = 0; k < NW; k++) w_model[k] = int'($signed(8'($urandom_range(0, 255))));
    for (int o = 0; o < O; o++) b_model[o] = int'($signed(8'($urandom_range(0, 255))));
    write_model();
    for (int t = 0; t < 8; t++) begin
      x = $urandom_range(0, 32'hFFFF_FFFF);
      out_ready = 1'b0;
      start_vector(x, 1'b1);
      wait_output(lat);
      checks++;
      if (lat != 9) begin errors++; $display("FAIL b2b_latency: txn %0d got %0d required 9", t, lat); end
      d = $urandom_range(0, 3);
      for (int c = 0; c < d; c++) tick();
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp) begin errors++; $display("FAIL b2b_scoreboard: txn %0d got %h required %h", t, data_out, exp); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; data_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    w_wr_en = 1'b0; w_addr = '0; w_data = '0;
    b_wr_en = 1'b0; b_addr = '0; b_data = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
FC_LAYER_SEQ -- requirements
Module: fc_layer_seq

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 160, number of input activations.
REQ-002 SHALL have parameter OUTPUT_SIZE, default 64, number of output neurons.
REQ-003 SHALL have parameter ACTIV_BITS, default 8, signed width of input/output activations.
REQ-004 SHALL have parameter WEIGHT_BITS, default 8, signed width of weights and biases.
REQ-005 SHALL have parameter ACC_BITS, default 32, signed accumulator width.
REQ-006 SHALL have parameter FRAC_BITS, default 0, fixed-point right shift applied to the accumulator.
REQ-007 SHALL have ports:
- clk  in  1  clock, one clock domain, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  INPUT_SIZE*ACTIV_BITS  input vector; element i at [i*ACTIV_BITS +: ACTIV_BITS].
- in_valid  in  1  data_in valid.
- in_ready  out  1  block can accept a vector.
- data_out  out  OUTPUT_SIZE*ACTIV_BITS  result vector; neuron o at [o*ACTIV_BITS +: ACTIV_BITS].
- out_valid  out  1  data_out valid.
- out_ready  in  1  consumer accepts data_out.
- w_wr_en  in  1  weight write strobe.
- w_addr  in  clog2(OUTPUT_SIZE*INPUT_SIZE)  weight address, o*INPUT_SIZE+i.
- w_data  in  WEIGHT_BITS  weight value.
- b_wr_en  in  1  bias write strobe.
- b_addr  in  clog2(OUTPUT_SIZE)  bias address.
- b_data  in  WEIGHT_BITS  bias value.

Function
REQ-008 SHALL implement a three-state FSM: IDLE, MAC, OUT.
REQ-009 In IDLE: in_ready=1. When in_valid=1, data_in SHALL be captured into an internal register and the FSM SHALL move to MAC.
REQ-010 In MAC: exactly one signed WEIGHT_BITS x ACTIV_BITS multiply-accumulate per cycle, over o = 0..OUTPUT_SIZE-1 (outer loop) and i = 0..INPUT_SIZE-1 (inner loop). MAC lasts OUTPUT_SIZE*INPUT_SIZE cycles.
REQ-011 For each neuron, the accumulator SHALL start at sign-extended bias[o] << FRAC_BITS; each product SHALL be sign-extended to ACC_BITS and added with wrap-around.
REQ-012 On a neuron's last product, the sum SHALL be arithmetically shifted right by FRAC_BITS, saturated to [-2^(ACTIV_BITS-1), 2^(ACTIV_BITS-1)-1], and written to data_out slot o.
REQ-013 After the final neuron the FSM SHALL enter OUT with out_valid=1, exactly OUTPUT_SIZE*INPUT_SIZE+1 cycles after the accept edge.
REQ-014 In OUT: out_valid=1, and data_out SHALL remain stable until out_ready=1. On the out_ready=1 cycle the FSM SHALL return to IDLE; out_valid=0 next cycle.
REQ-015 in_ready SHALL be 0 in MAC and OUT; in_valid SHALL be ignored there.
REQ-016 Weight and bias writes SHALL take effect only in IDLE. Writes in MAC or OUT, and writes with an out-of-range address, SHALL be ignored.
REQ-017 Simultaneous w_wr_en and b_wr_en SHALL both be performed.
REQ-018 data_out SHALL only change during MAC slot writes.

Reset
REQ-019 When rst=1 at a clock edge, the block SHALL: enter IDLE, set out_valid=0, set data_out=0, and clear the accumulator and counters. in_ready SHALL be 1 on the following cycle.
REQ-020 Reset SHALL NOT clear weight or bias storage; contents survive reset, including a reset asserted mid-MAC, which SHALL abort the computation with no output.

Configuration
REQ-021 With macro FC_LAYER_RELU_EN defined, a negative post-saturation result SHALL be written as 0; without it, the signed saturated value SHALL be written.

Verification (INPUT_SIZE=4, OUTPUT_SIZE=2, ACTIV_BITS=8, WEIGHT_BITS=8, FRAC_BITS=0)
REQ-022 All weights 1, biases 0 and 5, inputs {1,2,3,4}, out_ready=1 -> data_out = {10,15}; out_valid high exactly 9 cycles after accept, for 1 cycle.
REQ-023 All weights 100, inputs all 100, biases 0 -> both outputs 127 (positive saturation).
REQ-024 All weights -1, inputs {1,2,3,4}, biases 0 -> both outputs -10 (0xF6) without FC_LAYER_RELU_EN; 0 with it. Weights -128, inputs 127 -> -128 without the macro.
REQ-025 out_ready held 0 for 5 cycles in OUT, with in_valid=1 and weight writes issued -> data_out stable, in_ready=0, weights unchanged; out_valid drops the cycle after out_ready=1.
REQ-026 rst pulsed at MAC cycle 3 -> out_valid never rises, in_ready=1 next cycle. Re-sending the REQ-022 vector without reloading weights -> same {10,15}.
